// File: rtl/io_bus_arbiter_pkg.sv
// Shared definitions for the IO bus arbiter: core count, requester count,
// FSM state encoding and the captured-transaction record.
package io_bus_arbiter_pkg;

   localparam int NUM_IO_CORES   = 4;
   localparam int IO_ARB_NUM_REQ = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RD_WAIT = 2'd2
   } io_arb_state_t;

   typedef struct packed {
      logic                    wr;
      logic [NUM_IO_CORES-1:0] cs;
      logic [31:0]             address;
      logic [31:0]             wr_data;
   } io_arb_txn_t;

   function automatic logic cs_is_onehot(input logic [NUM_IO_CORES-1:0] cs);
      return (cs != '0) && ((cs & (cs - NUM_IO_CORES'(1))) == '0);
   endfunction

endpackage

// File: rtl/io_arb_rr_picker.sv
// Combinational 2-way round-robin select: a lone requester wins outright,
// a tie goes to the requester that was not granted last.
module io_arb_rr_picker
   import io_bus_arbiter_pkg::*;
(
   input  logic [IO_ARB_NUM_REQ-1:0] req,
   input  logic                      last_grant,
   output logic                      valid,
   output logic                      winner
);

   always_comb begin
      valid  = |req;
      winner = 1'b0;
      if (req[0] && req[1]) begin
         winner = ~last_grant;
      end else begin
         winner = req[1];
      end
   end

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-requester round-robin arbiter driving a single-outstanding IO bus.
// Build option IO_ARB_CS_CHECK_EN: non-one-hot core selects are granted with mN_err and never reach the bus.
module io_bus_arbiter
   import io_bus_arbiter_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    m0_req,
   input  logic                    m0_wr,
   input  logic [NUM_IO_CORES-1:0] m0_cs,
   input  logic [31:0]             m0_address,
   input  logic [31:0]             m0_wr_data,
   output logic                    m0_gnt,
   output logic                    m0_rd_valid,
   output logic [31:0]             m0_rd_data,
   input  logic                    m1_req,
   input  logic                    m1_wr,
   input  logic [NUM_IO_CORES-1:0] m1_cs,
   input  logic [31:0]             m1_address,
   input  logic [31:0]             m1_wr_data,
   output logic                    m1_gnt,
   output logic                    m1_rd_valid,
   output logic [31:0]             m1_rd_data,
`ifdef IO_ARB_CS_CHECK_EN
   output logic                    m0_err,
   output logic                    m1_err,
`endif
   output logic                    io_bus_m_rd_en,
   output logic                    io_bus_m_wr_en,
   output logic [NUM_IO_CORES-1:0] io_bus_m_cs,
   output logic [31:0]             io_bus_m_address,
   output logic [31:0]             io_bus_m_wr_data,
   input  logic [31:0]             io_bus_m_rd_data
);

   io_arb_state_t             state_q, state_d;
   logic                      last_grant_q;
   logic                      winner_q;
   io_arb_txn_t               txn_q;
   io_arb_txn_t               req_txn [IO_ARB_NUM_REQ];
   logic [IO_ARB_NUM_REQ-1:0] req_vec;
   logic [IO_ARB_NUM_REQ-1:0] gnt;
   logic [IO_ARB_NUM_REQ-1:0] rd_valid_q;
   logic [31:0]               rd_data_q [IO_ARB_NUM_REQ];
   logic                      pick_valid;
   logic                      pick_winner;
   logic                      cs_ok;
   logic                      bus_rd_en;
   logic                      bus_wr_en;
   logic [NUM_IO_CORES-1:0]   bus_cs;

   assign req_vec    = {m1_req, m0_req};
   assign req_txn[0] = '{wr: m0_wr, cs: m0_cs, address: m0_address, wr_data: m0_wr_data};
   assign req_txn[1] = '{wr: m1_wr, cs: m1_cs, address: m1_address, wr_data: m1_wr_data};

   io_arb_rr_picker u_picker (
      .req        (req_vec),
      .last_grant (last_grant_q),
      .valid      (pick_valid),
      .winner     (pick_winner)
   );

`ifdef IO_ARB_CS_CHECK_EN
   assign cs_ok = cs_is_onehot(txn_q.cs);
`else
   assign cs_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_valid) state_d = ISSUE;
         ISSUE:   state_d = txn_q.wr ? IDLE : RD_WAIT;
         RD_WAIT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A rejected select still earns its grant, but the bus never sees it.
   always_comb begin
      gnt       = '0;
      bus_rd_en = 1'b0;
      bus_wr_en = 1'b0;
      bus_cs    = '0;
      if (state_q == ISSUE) begin
         gnt[winner_q] = 1'b1;
         if (cs_ok) begin
            bus_wr_en = txn_q.wr;
            bus_rd_en = ~txn_q.wr;
            bus_cs    = txn_q.cs;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= 1'b1;
         winner_q     <= 1'b0;
         txn_q        <= '0;
         rd_valid_q   <= '0;
         for (int i = 0; i < IO_ARB_NUM_REQ; i++) begin
            rd_data_q[i] <= '0;
         end
      end else begin
         rd_valid_q <= '0;
         if (state_q == IDLE && pick_valid) begin
            winner_q     <= pick_winner;
            last_grant_q <= pick_winner;
            txn_q        <= req_txn[pick_winner];
         end
         if (state_q == RD_WAIT) begin
            rd_valid_q[winner_q] <= 1'b1;
            rd_data_q[winner_q]  <= cs_ok ? io_bus_m_rd_data : 32'd0;
         end
      end
   end

   assign m0_gnt           = gnt[0];
   assign m1_gnt           = gnt[1];
   assign m0_rd_valid      = rd_valid_q[0];
   assign m1_rd_valid      = rd_valid_q[1];
   assign m0_rd_data       = rd_data_q[0];
   assign m1_rd_data       = rd_data_q[1];
`ifdef IO_ARB_CS_CHECK_EN
   assign m0_err           = gnt[0] & ~cs_ok;
   assign m1_err           = gnt[1] & ~cs_ok;
`endif
   assign io_bus_m_rd_en   = bus_rd_en;
   assign io_bus_m_wr_en   = bus_wr_en;
   assign io_bus_m_cs      = bus_cs;
   assign io_bus_m_address = txn_q.address;
   assign io_bus_m_wr_data = txn_q.wr_data;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: drivers queue expected transactions,
// a negedge monitor checks grants, bus strobes and read returns against a reference model.
`timescale 1ns/1ps
module tb_io_bus_arbiter;
   import io_bus_arbiter_pkg::*;

   typedef struct {
      logic        wr;
      logic [3:0]  cs;
      logic [31:0] addr;
      logic [31:0] data;
      int          exp_gnt_cyc;
   } txn_t;

   typedef struct {
      int          n;
      logic [31:0] data;
      int          due;
   } rd_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_v = '0;
   logic [1:0]  wr_v  = '0;
   logic [3:0]  cs_v    [2];
   logic [31:0] addr_v  [2];
   logic [31:0] wdata_v [2];
   logic [31:0] bus_rd = '0;

   logic        m0_gnt, m1_gnt, m0_rd_valid, m1_rd_valid;
   logic [31:0] m0_rd_data, m1_rd_data;
   logic        rd_en, wr_en;
   logic [3:0]  bus_cs;
   logic [31:0] bus_addr, bus_wdata;
`ifdef IO_ARB_CS_CHECK_EN
   logic        m0_err, m1_err;
`endif

   wire [1:0]   gnt = {m1_gnt, m0_gnt};
   wire [1:0]   rdv = {m1_rd_valid, m0_rd_valid};
   logic [31:0] rdd [2];
   assign rdd[0] = m0_rd_data;
   assign rdd[1] = m1_rd_data;

   txn_t        pend [2][$];
   rd_t         rdq[$];
   logic [31:0] force_rd[$];
   int          log_n[$];
   int          log_c[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic        bus_pend = 1'b0;
   logic [31:0] bus_val  = '0;

   always #5 clk = ~clk;

   io_bus_arbiter dut (
      .clk              (clk),
      .rst              (rst),
      .m0_req           (req_v[0]),
      .m0_wr            (wr_v[0]),
      .m0_cs            (cs_v[0]),
      .m0_address       (addr_v[0]),
      .m0_wr_data       (wdata_v[0]),
      .m0_gnt           (m0_gnt),
      .m0_rd_valid      (m0_rd_valid),
      .m0_rd_data       (m0_rd_data),
      .m1_req           (req_v[1]),
      .m1_wr            (wr_v[1]),
      .m1_cs            (cs_v[1]),
      .m1_address       (addr_v[1]),
      .m1_wr_data       (wdata_v[1]),
      .m1_gnt           (m1_gnt),
      .m1_rd_valid      (m1_rd_valid),
      .m1_rd_data       (m1_rd_data),
`ifdef IO_ARB_CS_CHECK_EN
      .m0_err           (m0_err),
      .m1_err           (m1_err),
`endif
      .io_bus_m_rd_en   (rd_en),
      .io_bus_m_wr_en   (wr_en),
      .io_bus_m_cs      (bus_cs),
      .io_bus_m_address (bus_addr),
      .io_bus_m_wr_data (bus_wdata),
      .io_bus_m_rd_data (bus_rd)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Bus model: read data is valid only in the cycle after rd_en, junk otherwise.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         bus_rd   = bus_pend ? bus_val : $urandom;
         bus_pend = 1'b0;
      end
   end

   // Called and returns at posedge+1; exp_lat < 0 means grant latency is not checked.
   task automatic issue(input int n, input logic wr, input logic [3:0] cs,
                        input logic [31:0] addr, input logic [31:0] data, input int exp_lat);
      txn_t t;
      bit   got;
      got           = 1'b0;
      t.wr          = wr;
      t.cs          = cs;
      t.addr        = addr;
      t.data        = data;
      t.exp_gnt_cyc = (exp_lat < 0) ? -1 : cyc + exp_lat;
      pend[n].push_back(t);
      req_v[n]   = 1'b1;
      wr_v[n]    = wr;
      cs_v[n]    = cs;
      addr_v[n]  = addr;
      wdata_v[n] = data;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = gnt[n];
      end
      @(posedge clk);
      #1;
      req_v[n] = 1'b0;
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL gnt_timeout m%0d: no grant within 100 cycles, expected a grant", n);
         void'(pend[n].pop_back());
      end
   endtask

   task automatic rand_driver(input int n, input int count);
      logic [3:0] cs;
      int         gap;
      for (int k = 0; k < count; k++) begin
         gap = $urandom_range(0, 3);
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
         cs = ($urandom_range(0, 3) != 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
         issue(n, 1'($urandom), cs, $urandom, $urandom, -1);
      end
   endtask

   // Monitor / scoreboard
   initial begin
      logic [1:0]  prev_req;
      logic        rst_prev;
      int          last_model;
      logic [31:0] rd_model [2];
      int          n;
      int          exp_w;
      logic        bad;
      logic [31:0] data;
      txn_t        t;
      rd_t         r;
      prev_req    = '0;
      rst_prev    = 1'b0;
      last_model  = 1;
      rd_model[0] = '0;
      rd_model[1] = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            rdq.delete();
            bus_pend    = 1'b0;
            last_model  = 1;
            rd_model[0] = '0;
            rd_model[1] = '0;
         end else begin
            if (rst_prev) begin
               check("rst_gnt", {30'd0, gnt}, 32'd0);
               check("rst_rd_valid", {30'd0, rdv}, 32'd0);
               check("rst_strobes", {30'd0, rd_en, wr_en}, 32'd0);
               check("rst_cs", {28'd0, bus_cs}, 32'd0);
               check("rst_rd_data0", rdd[0], 32'd0);
               check("rst_rd_data1", rdd[1], 32'd0);
            end
            for (int k = 0; k < 2; k++) begin
               if (rdv[k]) begin
                  if (rdq.size() == 0) begin
                     check("rd_valid_unexpected", 32'd1, 32'd0);
                  end else begin
                     r = rdq.pop_front();
                     check("rd_valid_who", k, r.n);
                     check("rd_valid_cycle", cyc, r.due);
                     check("rd_data", rdd[k], r.data);
                     rd_model[r.n] = r.data;
                  end
               end
            end
            if (rdq.size() > 0 && rdq[0].due < cyc) begin
               check("rd_valid_missing", 32'd0, 32'd1);
               void'(rdq.pop_front());
            end
            check("rd_hold0", rdd[0], rd_model[0]);
            check("rd_hold1", rdd[1], rd_model[1]);

            if (gnt == 2'b11) begin
               check("gnt_onehot", {30'd0, gnt}, 32'd1);
            end else if (gnt != 2'b00) begin
               n = gnt[1] ? 1 : 0;
               if (prev_req == 2'b11)    exp_w = 1 - last_model;
               else if (prev_req == 2'b10) exp_w = 1;
               else                      exp_w = 0;
               check("arb_winner", n, exp_w);
               check("gnt_had_req", {31'd0, prev_req[n]}, 32'd1);
               check("one_outstanding", rdq.size(), 32'd0);
               last_model = n;
               if (pend[n].size() == 0) begin
                  check("gnt_without_txn", 32'd1, 32'd0);
               end else begin
                  t = pend[n].pop_front();
`ifdef IO_ARB_CS_CHECK_EN
                  bad = ($countones(t.cs) != 1);
                  check("err_winner", {31'd0, (n == 0) ? m0_err : m1_err}, {31'd0, bad});
                  check("err_other", {31'd0, (n == 0) ? m1_err : m0_err}, 32'd0);
`else
                  bad = 1'b0;
`endif
                  if (t.exp_gnt_cyc >= 0) check("gnt_latency", cyc, t.exp_gnt_cyc);
                  check("wr_en", {31'd0, wr_en}, {31'd0, !bad && t.wr});
                  check("rd_en", {31'd0, rd_en}, {31'd0, !bad && !t.wr});
                  check("bus_cs", {28'd0, bus_cs}, bad ? 32'd0 : {28'd0, t.cs});
                  check("bus_addr", bus_addr, t.addr);
                  if (t.wr) check("bus_wr_data", bus_wdata, t.data);
                  if (!t.wr) begin
                     data     = (force_rd.size() > 0) ? force_rd.pop_front() : $urandom;
                     bus_val  = data;
                     bus_pend = 1'b1;
                     r.n      = n;
                     r.data   = bad ? 32'd0 : data;
                     r.due    = cyc + 2;
                     rdq.push_back(r);
                  end
                  log_n.push_back(n);
                  log_c.push_back(cyc);
                  $display("txn m%0d %s cs=%h addr=%08h wdata=%08h cycle %0d",
                           n, t.wr ? "wr" : "rd", t.cs, t.addr, t.data, cyc);
               end
            end else begin
               check("idle_strobes", {30'd0, rd_en, wr_en}, 32'd0);
               check("idle_cs", {28'd0, bus_cs}, 32'd0);
            end
         end
         rst_prev = rst;
         prev_req = req_v;
      end
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         cs_v[i]    = '0;
         addr_v[i]  = '0;
         wdata_v[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Simultaneous writes straight out of reset: m0 first, m1 two cycles later.
      log_n.delete();
      log_c.delete();
      fork
         issue(0, 1'b1, 4'b0001, 32'h0000_0100, 32'h1111_0000, 1);
         issue(1, 1'b1, 4'b0100, 32'h0000_0200, 32'h2222_0000, -1);
      join
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("tie_first_m0", (log_n.size() > 0) ? log_n[0] : -1, 32'd0);
      check("tie_second_m1", (log_n.size() > 1) ? log_n[1] : -1, 32'd1);
      check("tie_spacing", (log_c.size() > 1) ? log_c[1] - log_c[0] : -1, 32'd2);

      // Single read with a known bus return.
      force_rd.push_back(32'hDEAD_BEEF);
      issue(0, 1'b0, 4'b0010, 32'h0000_0010, 32'h0, 1);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("single_read_data", m0_rd_data, 32'hDEAD_BEEF);

      // Write immediately followed by a read from the same requester.
      issue(1, 1'b1, 4'b1000, 32'h0000_0300, 32'hCAFE_0001, 1);
      issue(1, 1'b0, 4'b1000, 32'h0000_0304, 32'h0, 1);
      repeat (4) begin
         @(posedge clk);
         #1;
      end

      // Both requesters stream reads: grants must alternate every 3 cycles.
      log_n.delete();
      log_c.delete();
      fork
         for (int k = 0; k < 4; k++) issue(0, 1'b0, 4'b0001, 32'h400 + k, 32'h0, -1);
         for (int k = 0; k < 4; k++) issue(1, 1'b0, 4'b0010, 32'h500 + k, 32'h0, -1);
      join
      check("stream_count", log_n.size(), 32'd8);
      for (int i = 0; i < log_n.size(); i++) begin
         check("stream_order", log_n[i], i % 2);
         if (i > 0) check("stream_spacing", log_c[i] - log_c[i-1], 32'd3);
      end
      repeat (4) begin
         @(posedge clk);
         #1;
      end

      // Reset while the read is in RD_WAIT: its rd_valid must never appear.
      issue(0, 1'b0, 4'b0001, 32'h0000_0600, 32'h0, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      issue(1, 1'b0, 4'b0100, 32'h0000_0700, 32'h0, 1);
      repeat (3) begin
         @(posedge clk);
         #1;
      end

`ifdef IO_ARB_CS_CHECK_EN
      issue(1, 1'b0, 4'b0110, 32'h0000_0800, 32'h0, 1);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
`endif

      fork
         rand_driver(0, 30);
         rand_driver(1, 30);
      join
      repeat (6) begin
         @(posedge clk);
         #1;
      end
      check("drain_rdq", rdq.size(), 32'd0);
      check("drain_pend0", pend[0].size(), 32'd0);
      check("drain_pend1", pend[1].size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
